redirect_arb: RTL and testbench
===============================

# redirect_arb

Arbitration and sequencing controller between the pipeline's redirect sources (ID-stage jumps, EX-stage branch/jump resolution) and the single PC-redirect port of the fetch unit. It also forwards EX branch-predictor updates to the predictor table through a separate handshake. It sits beside pipeEX/pipeID and the IF PC logic. The block serialises all redirects, applies EX-over-ID priority, and emits one-cycle flush pulses to the younger stages.

## Interface
- REG_SZ, 32, PC / target width
- TAG_W, 10, predictor tag width
- CNT_W, 16, width of redirect statistics counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_jp_e  in  1  ID redirect request (level, held until id_jp_ack)
- id_jp_pc  in  REG_SZ  ID redirect target
- id_jp_ack  out  1  one-cycle acknowledge to ID
- ex_jp_e  in  1  EX resolution request (level, held until ex_jp_ack)
- ex_jp_pc  in  REG_SZ  EX target; value 0 means "resolved, not taken, no redirect"
- ex_jp_ack  out  1  one-cycle acknowledge to EX
- ex_bp_we  in  1  EX predictor-update request (level)
- ex_bp_tag  in  TAG_W  predictor tag
- ex_bp_t  in  1  taken outcome
- ex_bp_wack  out  1  one-cycle acknowledge to EX
- pc_jp_e  out  1  redirect request to fetch
- pc_jp_pc  out  REG_SZ  redirect target to fetch
- pc_jp_ack  in  1  fetch acknowledge
- bp_we  out  1  predictor write request
- bp_tag  out  TAG_W  latched tag
- bp_t  out  1  latched outcome
- bp_wack  in  1  predictor write acknowledge
- flush_if  out  1  one-cycle flush of IF/ID buffer
- flush_id  out  1  one-cycle flush of ID/EX buffer
- busy  out  1  redirect FSM not in IDLE
- redirect_cnt  out  CNT_W  count of completed redirects, saturating

## Operation
- Redirect FSM states: IDLE, FWD, ACK, HOLD.
- IDLE samples requests each edge. Priority is EX over ID.
- EX request, ex_jp_pc != 0:
  - Latch the target and go to FWD.
  - If id_jp_e is also high, the ID request is squashed: it is pulsed id_jp_ack together with ex_jp_ack in ACK, and never forwarded.
- EX request, ex_jp_pc == 0: go directly to ACK. No pc_jp_e, no flush, no count. A pending ID request is not squashed.
- ID request only: latch the target and go to FWD.
- FWD:
  - pc_jp_e=1, pc_jp_pc=latched target, held until pc_jp_ack is sampled high.
  - On that edge, go to ACK.
- ACK (one cycle):
  - pc_jp_e=0; pulse the owner's ack.
  - flush_if=1 for any forwarded redirect; flush_id=1 only for an EX-sourced forwarded redirect.
  - redirect_cnt increments on forwarded redirects, saturating at all-ones.
  - Next state HOLD.
- HOLD (one cycle): no sampling, giving sources the edge to drop their request; then return to IDLE.
- Predictor FSM runs independently: BP_IDLE, BP_WR, BP_ACK, BP_HOLD.
  - BP_IDLE: on ex_bp_we, latch tag/t and go to BP_WR.
  - BP_WR: bp_we=1 until bp_wack is sampled high.
  - BP_ACK: ex_bp_wack pulse for one cycle.
  - BP_HOLD: one cycle, then BP_IDLE.
  - bp_tag/bp_t hold their latched value until the next latch.
- Reset (async, any time):
  - All outputs go to 0; both FSMs go to IDLE; latched targets and counter are cleared.
  - In-flight requests are lost. Sources are reset by the same rst.

## Timing
- Request sampled at edge N → pc_jp_e high after edge N (cycle N+1).
- pc_jp_ack sampled at edge M → pc_jp_e low, ack/flush high during cycle M+1; HOLD in cycle M+2; IDLE samples at edge M+3.
- Minimum forwarded-redirect turnaround is 4 cycles, with pc_jp_ack returned immediately. Not-taken EX resolution takes 3 cycles (IDLE→ACK→HOLD→IDLE).
- A pc_jp_ack already high when FWD is entered is accepted at the first FWD edge.
- Redirect and predictor paths may be active in the same cycle; there is no interaction.
- Request changes of a source during FWD are ignored. Target stability after sampling is guaranteed by latching.
- Redirects are never dropped or reordered, except that the ID request is squashed by a simultaneous taken EX request.

## Test plan
- Reset mid-FWD: ID req pc=0x40, assert rst during FWD → all outputs 0 asynchronously; after release, no pc_jp_e without a new request.
- ID only: id_jp_pc=0x100, pc_jp_ack 2 cycles later → pc_jp_pc=0x100, id_jp_ack one cycle, flush_if=1, flush_id=0, redirect_cnt=1.
- Simultaneous: ID 0x100 + EX 0x200 same edge → only 0x200 forwarded; ex_jp_ack and id_jp_ack pulse together; flush_if=flush_id=1; redirect_cnt+1.
- EX not taken with ID pending: ex_jp_pc=0, id_jp_pc=0x80 → ex_jp_ack after 1 cycle, no flush; then ID 0x80 forwarded normally.
- Predictor update concurrent with redirect: ex_bp_tag=0x3A5, t=1, bp_wack after 3 cycles → bp_tag=0x3A5, bp_t=1, ex_bp_wack one pulse; redirect timing unchanged.
- Counter saturation: CNT_W=2, 5 forwarded redirects → redirect_cnt stays 3.

Source files
------------

// File: rtl/redirect_arb_if.sv
// Redirect arbiter bundle: ID/EX redirect requests, EX predictor updates,
// fetch redirect port, predictor write port, flush pulses and statistics.
interface redirect_arb_if #(
    parameter int REG_SZ = 32,
    parameter int TAG_W  = 10,
    parameter int CNT_W  = 16
);
    logic              id_jp_e;
    logic [REG_SZ-1:0] id_jp_pc;
    logic              id_jp_ack;
    logic              ex_jp_e;
    logic [REG_SZ-1:0] ex_jp_pc;
    logic              ex_jp_ack;
    logic              ex_bp_we;
    logic [TAG_W-1:0]  ex_bp_tag;
    logic              ex_bp_t;
    logic              ex_bp_wack;
    logic              pc_jp_e;
    logic [REG_SZ-1:0] pc_jp_pc;
    logic              pc_jp_ack;
    logic              bp_we;
    logic [TAG_W-1:0]  bp_tag;
    logic              bp_t;
    logic              bp_wack;
    logic              flush_if;
    logic              flush_id;
    logic              busy;
    logic [CNT_W-1:0]  redirect_cnt;

    // Arbiter side
    modport slave (
        input  id_jp_e, id_jp_pc, ex_jp_e, ex_jp_pc,
        input  ex_bp_we, ex_bp_tag, ex_bp_t, pc_jp_ack, bp_wack,
        output id_jp_ack, ex_jp_ack, ex_bp_wack, pc_jp_e, pc_jp_pc,
        output bp_we, bp_tag, bp_t, flush_if, flush_id, busy, redirect_cnt
    );

    // Pipeline / fetch / predictor side
    modport master (
        output id_jp_e, id_jp_pc, ex_jp_e, ex_jp_pc,
        output ex_bp_we, ex_bp_tag, ex_bp_t, pc_jp_ack, bp_wack,
        input  id_jp_ack, ex_jp_ack, ex_bp_wack, pc_jp_e, pc_jp_pc,
        input  bp_we, bp_tag, bp_t, flush_if, flush_id, busy, redirect_cnt
    );
endinterface

// File: rtl/redirect_arb.sv
// Serialises ID/EX redirects onto the fetch port (EX wins, taken EX squashes ID) and forwards predictor updates.
// Latency: request edge -> pc_jp_e next cycle; fetch ack -> ack/flush next cycle, then one HOLD cycle.
// Backpressure: pc_jp_e / bp_we held until pc_jp_ack / bp_wack; sources hold requests until their ack pulse.
module redirect_arb #(
    parameter int REG_SZ = 32,
    parameter int TAG_W  = 10,
    parameter int CNT_W  = 16
) (
    input logic           clk,
    input logic           rst,
    redirect_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, ACK = 2'd2, HOLD = 2'd3} rd_state_e;
    typedef enum logic [1:0] {BP_IDLE = 2'd0, BP_WR = 2'd1, BP_ACK = 2'd2, BP_HOLD = 2'd3} bp_state_e;

    rd_state_e         state_q, state_d;
    logic [REG_SZ-1:0] tgt_q, tgt_d;
    logic              ex_src_q, ex_src_d;
    logic              squash_q, squash_d;
    logic              pc_jp_e_q, pc_jp_e_d;
    logic              id_ack_q, id_ack_d;
    logic              ex_ack_q, ex_ack_d;
    logic              flush_if_q, flush_if_d;
    logic              flush_id_q, flush_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    bp_state_e         bp_state_q, bp_state_d;
    logic [TAG_W-1:0]  bp_tag_q, bp_tag_d;
    logic              bp_t_q, bp_t_d;
    logic              bp_we_q, bp_we_d;
    logic              bp_wack_q, bp_wack_d;

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        ex_src_d   = ex_src_q;
        squash_d   = squash_q;
        cnt_d      = cnt_q;
        pc_jp_e_d  = 1'b0;
        id_ack_d   = 1'b0;
        ex_ack_d   = 1'b0;
        flush_if_d = 1'b0;
        flush_id_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ex_jp_e) begin
                    if (bus.ex_jp_pc != '0) begin
                        tgt_d     = bus.ex_jp_pc;
                        ex_src_d  = 1'b1;
                        squash_d  = bus.id_jp_e;
                        pc_jp_e_d = 1'b1;
                        state_d   = FWD;
                    end else begin
                        // Not-taken resolution: ack only, a pending ID request survives
                        ex_ack_d = 1'b1;
                        state_d  = ACK;
                    end
                end else if (bus.id_jp_e) begin
                    tgt_d     = bus.id_jp_pc;
                    ex_src_d  = 1'b0;
                    squash_d  = 1'b0;
                    pc_jp_e_d = 1'b1;
                    state_d   = FWD;
                end
            end
            FWD: begin
                if (bus.pc_jp_ack) begin
                    ex_ack_d   = ex_src_q;
                    id_ack_d   = !ex_src_q || squash_q;
                    flush_if_d = 1'b1;
                    flush_id_d = ex_src_q;
                    cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d    = ACK;
                end else begin
                    pc_jp_e_d = 1'b1;
                end
            end
            ACK:     state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bp_state_d = bp_state_q;
        bp_tag_d   = bp_tag_q;
        bp_t_d     = bp_t_q;
        bp_we_d    = 1'b0;
        bp_wack_d  = 1'b0;
        case (bp_state_q)
            BP_IDLE: begin
                if (bus.ex_bp_we) begin
                    bp_tag_d   = bus.ex_bp_tag;
                    bp_t_d     = bus.ex_bp_t;
                    bp_we_d    = 1'b1;
                    bp_state_d = BP_WR;
                end
            end
            BP_WR: begin
                if (bus.bp_wack) begin
                    bp_wack_d  = 1'b1;
                    bp_state_d = BP_ACK;
                end else begin
                    bp_we_d = 1'b1;
                end
            end
            BP_ACK:  bp_state_d = BP_HOLD;
            BP_HOLD: bp_state_d = BP_IDLE;
            default: bp_state_d = BP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            ex_src_q   <= 1'b0;
            squash_q   <= 1'b0;
            pc_jp_e_q  <= 1'b0;
            id_ack_q   <= 1'b0;
            ex_ack_q   <= 1'b0;
            flush_if_q <= 1'b0;
            flush_id_q <= 1'b0;
            cnt_q      <= '0;
            bp_state_q <= BP_IDLE;
            bp_tag_q   <= '0;
            bp_t_q     <= 1'b0;
            bp_we_q    <= 1'b0;
            bp_wack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            ex_src_q   <= ex_src_d;
            squash_q   <= squash_d;
            pc_jp_e_q  <= pc_jp_e_d;
            id_ack_q   <= id_ack_d;
            ex_ack_q   <= ex_ack_d;
            flush_if_q <= flush_if_d;
            flush_id_q <= flush_id_d;
            cnt_q      <= cnt_d;
            bp_state_q <= bp_state_d;
            bp_tag_q   <= bp_tag_d;
            bp_t_q     <= bp_t_d;
            bp_we_q    <= bp_we_d;
            bp_wack_q  <= bp_wack_d;
        end
    end

    assign bus.pc_jp_e      = pc_jp_e_q;
    assign bus.pc_jp_pc     = tgt_q;
    assign bus.id_jp_ack    = id_ack_q;
    assign bus.ex_jp_ack    = ex_ack_q;
    assign bus.flush_if     = flush_if_q;
    assign bus.flush_id     = flush_id_q;
    assign bus.redirect_cnt = cnt_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.bp_we        = bp_we_q;
    assign bus.bp_tag       = bp_tag_q;
    assign bus.bp_t         = bp_t_q;
    assign bus.ex_bp_wack   = bp_wack_q;
endmodule

// File: tb/tb_redirect_arb.sv
// Bench for redirect_arb: per-scenario tasks compare cycle traces against a
// transaction-level expectation derived from the redirect/predictor rules.
module tb_redirect_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_total = 0;

    always #5 clk = ~clk;

    redirect_arb_if #(.REG_SZ(32), .TAG_W(10), .CNT_W(16)) bi ();
    redirect_arb_if #(.REG_SZ(32), .TAG_W(10), .CNT_W(2))  bs ();

    // Small-counter copy sees identical stimulus
    assign bs.id_jp_e   = bi.id_jp_e;
    assign bs.id_jp_pc  = bi.id_jp_pc;
    assign bs.ex_jp_e   = bi.ex_jp_e;
    assign bs.ex_jp_pc  = bi.ex_jp_pc;
    assign bs.ex_bp_we  = bi.ex_bp_we;
    assign bs.ex_bp_tag = bi.ex_bp_tag;
    assign bs.ex_bp_t   = bi.ex_bp_t;
    assign bs.pc_jp_ack = bi.pc_jp_ack;
    assign bs.bp_wack   = bi.bp_wack;

    redirect_arb #(.REG_SZ(32), .TAG_W(10), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bi));
    redirect_arb #(.REG_SZ(32), .TAG_W(10), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(bs));

    function automatic logic [127:0] out_vec();
        return {bi.pc_jp_e, bi.pc_jp_pc, bi.id_jp_ack, bi.ex_jp_ack, bi.flush_if, bi.flush_id,
                bi.busy, bi.redirect_cnt, bi.bp_we, bi.bp_tag, bi.bp_t, bi.ex_bp_wack, 30'd0};
    endfunction

    task automatic test_reset();
        bi.id_jp_e = 0; bi.id_jp_pc = 0; bi.ex_jp_e = 0; bi.ex_jp_pc = 0;
        bi.ex_bp_we = 0; bi.ex_bp_tag = 0; bi.ex_bp_t = 0; bi.pc_jp_ack = 0; bi.bp_wack = 0;
        rst = 1'b1;
        #2;
        n_checks++;
        if (out_vec() !== 128'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0", out_vec());
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bi.busy !== 1'b0 || bi.pc_jp_e !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle got busy=%b pc_jp_e=%b exp 0 0", bi.busy, bi.pc_jp_e);
        end
    endtask

    task automatic test_reset_mid_fwd();
        int seen;
        @(negedge clk);
        bi.id_jp_e = 1; bi.id_jp_pc = 32'h40; bi.pc_jp_ack = 0;
        @(negedge clk);
        n_checks++;
        if (bi.pc_jp_e !== 1'b1 || bi.pc_jp_pc !== 32'h40) begin
            n_fail++; $display("FAIL mid_fwd_pre got e=%b pc=%h exp 1 00000040", bi.pc_jp_e, bi.pc_jp_pc);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_vec() !== 128'd0) begin
            n_fail++; $display("FAIL mid_fwd_async_reset got=%h exp=0", out_vec());
        end
        bi.id_jp_e = 0; bi.id_jp_pc = 0;
        exp_total = 0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bi.pc_jp_e === 1'b1 || bi.busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL post_reset_quiet got active_cycles=%0d exp=0", seen);
        end
    endtask

    task automatic run_redirect(input logic id_e, input logic [31:0] id_pc,
                                input logic ex_e, input logic [31:0] ex_pc,
                                input int d, input string nm);
        logic taken;
        logic [31:0] tgt;
        int nfwd, e_first, e_exa, e_ida, e_last;
        int npc, first, exa_n, exa_i, ida_n, ida_i, fif_n, fif_i, fid_n, fid_i, bad_pc, last_busy, hi;
        taken = ex_e && (ex_pc != 0);
        if (taken) begin
            nfwd = 1; tgt = ex_pc; e_first = 0; e_exa = d + 1; e_ida = id_e ? d + 1 : -1;
        end else if (ex_e) begin
            nfwd = id_e ? 1 : 0; tgt = id_pc; e_first = id_e ? 3 : -1; e_exa = 0; e_ida = id_e ? d + 4 : -1;
        end else begin
            nfwd = 1; tgt = id_pc; e_first = 0; e_exa = -1; e_ida = d + 1;
        end
        e_last = (e_exa > e_ida) ? e_exa : e_ida;
        exp_total += nfwd;
        npc = 0; first = -1; exa_n = 0; exa_i = -1; ida_n = 0; ida_i = -1;
        fif_n = 0; fif_i = -1; fid_n = 0; fid_i = -1; bad_pc = 0; last_busy = -1; hi = 0;

        @(negedge clk);
        bi.id_jp_e = id_e; bi.id_jp_pc = id_pc; bi.ex_jp_e = ex_e; bi.ex_jp_pc = ex_pc;
        bi.pc_jp_ack = (d == 0);
        for (int idx = 0; idx < d + 12; idx++) begin
            @(negedge clk);
            if (bi.pc_jp_e === 1'b1) begin
                npc++; hi++;
                if (first < 0) first = idx;
                if (bi.pc_jp_pc !== tgt) bad_pc++;
                bi.pc_jp_ack = (hi > d);
            end else begin
                hi = 0;
                bi.pc_jp_ack = (d == 0);
            end
            if (bi.ex_jp_ack === 1'b1) begin exa_n++; exa_i = idx; bi.ex_jp_e = 0; end
            if (bi.id_jp_ack === 1'b1) begin ida_n++; ida_i = idx; bi.id_jp_e = 0; end
            if (bi.flush_if === 1'b1) begin fif_n++; fif_i = idx; end
            if (bi.flush_id === 1'b1) begin fid_n++; fid_i = idx; end
            if (bi.busy === 1'b1) last_busy = idx;
        end
        bi.pc_jp_ack = 0; bi.id_jp_e = 0; bi.ex_jp_e = 0;

        n_checks++;
        if (npc !== nfwd * (d + 1)) begin
            n_fail++; $display("FAIL %s pc_jp_e_cycles got=%0d exp=%0d", nm, npc, nfwd * (d + 1));
        end
        n_checks++;
        if (first !== e_first) begin
            n_fail++; $display("FAIL %s first_fwd_cycle got=%0d exp=%0d", nm, first, e_first);
        end
        n_checks++;
        if (bad_pc !== 0) begin
            n_fail++; $display("FAIL %s pc_jp_pc_wrong_cycles got=%0d exp=0 (target %h)", nm, bad_pc, tgt);
        end
        n_checks++;
        if (exa_n !== (ex_e ? 1 : 0) || exa_i !== e_exa) begin
            n_fail++; $display("FAIL %s ex_jp_ack got n=%0d at=%0d exp n=%0d at=%0d", nm, exa_n, exa_i, ex_e ? 1 : 0, e_exa);
        end
        n_checks++;
        if (ida_n !== (id_e ? 1 : 0) || ida_i !== e_ida) begin
            n_fail++; $display("FAIL %s id_jp_ack got n=%0d at=%0d exp n=%0d at=%0d", nm, ida_n, ida_i, id_e ? 1 : 0, e_ida);
        end
        n_checks++;
        if (fif_n !== nfwd || fif_i !== (nfwd != 0 ? e_last : -1)) begin
            n_fail++; $display("FAIL %s flush_if got n=%0d at=%0d exp n=%0d at=%0d", nm, fif_n, fif_i, nfwd, nfwd != 0 ? e_last : -1);
        end
        n_checks++;
        if (fid_n !== (taken ? 1 : 0) || fid_i !== (taken ? d + 1 : -1)) begin
            n_fail++; $display("FAIL %s flush_id got n=%0d at=%0d exp n=%0d at=%0d", nm, fid_n, fid_i, taken ? 1 : 0, taken ? d + 1 : -1);
        end
        n_checks++;
        if (last_busy !== e_last + 1) begin
            n_fail++; $display("FAIL %s busy_last_cycle got=%0d exp=%0d", nm, last_busy, e_last + 1);
        end
        n_checks++;
        if (bi.redirect_cnt !== 16'(exp_total)) begin
            n_fail++; $display("FAIL %s redirect_cnt got=%0d exp=%0d", nm, bi.redirect_cnt, exp_total);
        end
    endtask

    task automatic run_bp(input logic [9:0] tag, input logic t, input int k, input string nm);
        int nwe, first, wn, wi, bad, hi;
        nwe = 0; first = -1; wn = 0; wi = -1; bad = 0; hi = 0;
        @(negedge clk);
        bi.ex_bp_we = 1; bi.ex_bp_tag = tag; bi.ex_bp_t = t; bi.bp_wack = 0;
        for (int idx = 0; idx < k + 10; idx++) begin
            @(negedge clk);
            bi.ex_bp_tag = ~tag; bi.ex_bp_t = ~t;
            if (bi.bp_we === 1'b1) begin
                nwe++; hi++;
                if (first < 0) first = idx;
                if (bi.bp_tag !== tag || bi.bp_t !== t) bad++;
                bi.bp_wack = (hi > k);
            end else begin
                bi.bp_wack = 0;
            end
            if (bi.ex_bp_wack === 1'b1) begin wn++; wi = idx; bi.ex_bp_we = 0; end
        end
        bi.ex_bp_we = 0; bi.bp_wack = 0;
        n_checks++;
        if (nwe !== k + 1 || first !== 0) begin
            n_fail++; $display("FAIL %s bp_we got cycles=%0d first=%0d exp cycles=%0d first=0", nm, nwe, first, k + 1);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL %s bp_tag_during_write got bad=%0d exp=0", nm, bad);
        end
        n_checks++;
        if (wn !== 1 || wi !== k + 1) begin
            n_fail++; $display("FAIL %s ex_bp_wack got n=%0d at=%0d exp n=1 at=%0d", nm, wn, wi, k + 1);
        end
        n_checks++;
        if (bi.bp_tag !== tag || bi.bp_t !== t) begin
            n_fail++; $display("FAIL %s bp_tag_hold got tag=%h t=%b exp tag=%h t=%b", nm, bi.bp_tag, bi.bp_t, tag, t);
        end
    endtask

    task automatic test_id_only();
        run_redirect(1'b1, 32'h100, 1'b0, 32'h0, 2, "id_only");
    endtask

    task automatic test_simultaneous();
        run_redirect(1'b1, 32'h100, 1'b1, 32'h200, 1, "simultaneous");
    endtask

    task automatic test_ex_not_taken();
        run_redirect(1'b1, 32'h80, 1'b1, 32'h0, 0, "ex_nt_id_pending");
        run_redirect(1'b0, 32'h0, 1'b1, 32'h0, 0, "ex_nt_alone");
    endtask

    task automatic test_bp_concurrent();
        fork
            run_redirect(1'b1, 32'h300, 1'b0, 32'h0, 1, "redirect_with_bp");
            run_bp(10'h3A5, 1'b1, 3, "bp_concurrent");
        join
        run_bp(10'($urandom), 1'($urandom), 0, "bp_fast");
    endtask

    task automatic test_random();
        for (int i = 0; i < 14; i++) begin
            int mode;
            logic [31:0] ipc, epc;
            mode = $urandom_range(0, 4);
            ipc  = $urandom();
            epc  = $urandom() | 32'h4;
            case (mode)
                0:       run_redirect(1'b1, ipc, 1'b0, 32'h0, $urandom_range(0, 3), "rnd_id");
                1:       run_redirect(1'b0, ipc, 1'b1, epc,   $urandom_range(0, 3), "rnd_ex");
                2:       run_redirect(1'b1, ipc, 1'b1, epc,   $urandom_range(0, 3), "rnd_both");
                3:       run_redirect(1'b1, ipc, 1'b1, 32'h0, $urandom_range(0, 3), "rnd_nt_id");
                default: run_redirect(1'b0, ipc, 1'b1, 32'h0, $urandom_range(0, 3), "rnd_nt");
            endcase
        end
    endtask

    task automatic test_saturation();
        int exp_small;
        for (int i = 0; i < 5; i++)
            run_redirect(1'b0, 32'h0, 1'b1, 32'h1000 + 32'(i * 4), 0, "sat_fwd");
        exp_small = (exp_total > 3) ? 3 : exp_total;
        n_checks++;
        if (bs.redirect_cnt !== 2'(exp_small)) begin
            n_fail++; $display("FAIL cnt_saturation got=%0d exp=%0d", bs.redirect_cnt, exp_small);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_fwd();
        test_id_only();
        test_simultaneous();
        test_ex_not_taken();
        test_bp_concurrent();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
